// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and types for the interrupt controller.
//   - register offsets within the 4-entry IO window
//   - CAUSE_NONE, the CAUSE read value when no enabled source is pending
//   - intc_state_t, the request/holdoff FSM encoding
//   - lowest_set_idx(), the priority encoder behind the CAUSE register
package intc_pkg;

  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_MASK    = 2'd1;
  localparam logic [1:0] OFS_CAUSE   = 2'd2;
  localparam logic [1:0] OFS_LEVEL   = 2'd3;

  localparam logic [7:0] CAUSE_NONE  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLDOFF
  } intc_state_t;

  // Index of the lowest set bit, or CAUSE_NONE when no bit is set.
  // Scanning from the top down means the last hit is the lowest index,
  // so source 0 has the highest priority.
  function automatic logic [7:0] lowest_set_idx(input logic [7:0] vec);
    logic [7:0] idx;
    idx = CAUSE_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-source synchronizer chain plus rising-edge detect.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   irq          asynchronous request lines (NUM_SRC bits)
//   sync_level   synchronized level, output of the last synchronizer flop
//   rise_pulse   one-cycle pulse when sync_level goes 0 -> 1
module irq_sync_edge #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  output logic [NUM_SRC-1:0] sync_level,
  output logic [NUM_SRC-1:0] rise_pulse
);

  logic [NUM_SRC-1:0] stage [SYNC_STAGES];
  logic [NUM_SRC-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchronizer array is a handful of flops, not a RAM, so it
      // is reset element by element; a stale 1 here would fake a request.
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      level_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this loop into a shift chain.
      stage[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      level_q <= stage[SYNC_STAGES-1];
    end
  end

  assign sync_level = stage[SYNC_STAGES-1];
  assign rise_pulse = sync_level & ~level_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches peripheral interrupt requests as pending,
// masks them, and drives INTERRUPT to the control unit until software acks.
// Registers sit on the port-mapped IO bus at PORT_BASE..PORT_BASE+3:
//   +0 PENDING (read, W1C)  +1 MASK (R/W)  +2 CAUSE (RO)  +3 LEVEL / reserved
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   IRQ_IN         asynchronous active-high request lines
//   PORT_ID        IO address; OUT_PORT write data; IO_STRB write strobe
//   IN_PORT        combinational read data for the addressed register
//   IN_SEL         PORT_ID falls inside this block's 4-port window
//   INTERRUPT      registered request to the control unit
// Build option: define INTC_LEVEL_CFG_EN to make offset 3 a R/W LEVEL
// register selecting level-sensitive sources; otherwise offset 3 reads 0
// and every source is edge-triggered.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int         NUM_SRC     = 8,
  parameter logic [7:0] PORT_BASE   = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_PORT,
  output logic               IN_SEL,
  output logic               INTERRUPT
);

  logic [NUM_SRC-1:0] sync_level;
  logic [NUM_SRC-1:0] rise_pulse;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] level_cfg;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [1:0]         ofs;
  logic               wr_hit;
  logic               active;
  intc_state_t        state;

  irq_sync_edge #(
    .NUM_SRC     (NUM_SRC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .irq        (IRQ_IN),
    .sync_level (sync_level),
    .rise_pulse (rise_pulse)
  );

  // PORT_BASE is 4-aligned, so the window decode is just the upper 6 bits.
  assign IN_SEL = (PORT_ID[7:2] == PORT_BASE[7:2]);
  assign ofs    = PORT_ID[1:0];
  assign wr_hit = IO_STRB && IN_SEL;

`ifdef INTC_LEVEL_CFG_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                      level_cfg <= '0;
    else if (wr_hit && ofs == OFS_LEVEL) level_cfg <= OUT_PORT[NUM_SRC-1:0];
  end
`else
  assign level_cfg = '0;
`endif

  // Level-configured sources re-assert every cycle their line is high, which
  // is what makes a W1C ineffective until the peripheral drops the line.
  assign set_vec = rise_pulse | (level_cfg & sync_level);
  assign clr_vec = (wr_hit && ofs == OFS_PENDING) ? OUT_PORT[NUM_SRC-1:0] : '0;
  assign active  = |(pending & mask);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      // Set is OR-ed in after the clear so a new event never gets lost
      // to an ack that lands in the same cycle.
      pending <= (pending & ~clr_vec) | set_vec;
      if (wr_hit && ofs == OFS_MASK) mask <= OUT_PORT[NUM_SRC-1:0];
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns IN_PORT and no latch forms.
    IN_PORT = '0;
    if (IN_SEL) begin
      case (ofs)
        OFS_PENDING: IN_PORT = 8'(pending);
        OFS_MASK:    IN_PORT = 8'(mask);
        OFS_CAUSE:   IN_PORT = lowest_set_idx(8'(pending & mask));
        default:     IN_PORT = 8'(level_cfg);
      endcase
    end
  end

  // INTERRUPT is registered alongside the state so it is glitch-free, and
  // the holdoff state forces a low cycle between back-to-back requests.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      INTERRUPT <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active) begin
            state     <= ST_REQ;
            INTERRUPT <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!active) begin
            state     <= ST_HOLDOFF;
            INTERRUPT <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          state     <= ST_IDLE;
          INTERRUPT <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          INTERRUPT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: self-checking bench for interrupt_controller.
// Reset-time register reads come from a vector table; the multi-cycle
// behaviours (edge latency, ack/holdoff, masking, priority, set/clear
// collision, level mode, async reset) are hand-written sequences. Every
// expected value is pushed to a scoreboard queue when the stimulus is
// driven and popped when the DUT output is sampled.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] IRQ_IN = '0;
  logic [7:0] PORT_ID = '0;
  logic [7:0] OUT_PORT = '0;
  logic       IO_STRB = 1'b0;
  logic [7:0] IN_PORT;
  logic       IN_SEL;
  logic       INTERRUPT;

  interrupt_controller #(
    .NUM_SRC     (8),
    .PORT_BASE   (8'hF0),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IRQ_IN    (IRQ_IN),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_PORT   (IN_PORT),
    .IN_SEL    (IN_SEL),
    .INTERRUPT (INTERRUPT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  typedef struct {
    logic [7:0] port_id;
    logic [7:0] exp_in;
    logic       exp_sel;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input string name, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [7:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h, expected an entry", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input string name, input logic [7:0] addr, input logic [7:0] exp);
    PORT_ID = addr;
    expect_push(name, exp);
    #1;
    pop_cmp(IN_PORT);
  endtask

  task automatic irq_is(input string name, input logic exp);
    expect_push(name, {7'd0, exp});
    pop_cmp({7'd0, INTERRUPT});
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    PORT_ID  = addr;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    OUT_PORT = '0;
  endtask

  // Hold the given lines high across two active edges, then drop them.
  task automatic pulse(input logic [7:0] bits);
    IRQ_IN = IRQ_IN | bits;
    tick();
    tick();
    IRQ_IN = IRQ_IN & ~bits;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{8'hF0, 8'h00, 1'b1};
    vecs[1] = '{8'hF1, 8'h00, 1'b1};
    vecs[2] = '{8'hF2, 8'hFF, 1'b1};
    vecs[3] = '{8'hF3, 8'h00, 1'b1};
    vecs[4] = '{8'h10, 8'h00, 1'b0};
    vecs[5] = '{8'hEF, 8'h00, 1'b0};
    vecs[6] = '{8'hF4, 8'h00, 1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    irq_is("irq_in_reset", 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    irq_is("irq_after_reset", 1'b0);

    foreach (vecs[i]) begin
      PORT_ID = vecs[i].port_id;
      expect_push($sformatf("rst_in_port_%h", vecs[i].port_id), vecs[i].exp_in);
      expect_push($sformatf("rst_in_sel_%h", vecs[i].port_id), {7'd0, vecs[i].exp_sel});
      #1;
      pop_cmp(IN_PORT);
      pop_cmp({7'd0, IN_SEL});
    end

    // Edge on source 2 with it enabled: pending on edge 3, INTERRUPT on edge 4
    wr(8'hF1, 8'h04);
    rd("mask_readback", 8'hF1, 8'h04);
    pulse(8'h04);
    rd("pend_before_edge3", 8'hF0, 8'h00);
    tick();
    rd("pend_edge3", 8'hF0, 8'h04);
    irq_is("irq_low_edge3", 1'b0);
    tick();
    irq_is("irq_high_edge4", 1'b1);
    rd("cause_src2", 8'hF2, 8'h02);

    // Ack: INTERRUPT falls one cycle after the write, then holdoff and idle
    wr(8'hF0, 8'h04);
    rd("pend_after_ack", 8'hF0, 8'h00);
    irq_is("irq_on_ack_edge", 1'b1);
    tick();
    irq_is("irq_holdoff", 1'b0);
    tick();
    irq_is("irq_idle_after_holdoff", 1'b0);
    rd("cause_none", 8'hF2, 8'hFF);

    // Masked source still latches; unmasking raises the request
    wr(8'hF1, 8'h00);
    pulse(8'h20);
    tick();
    rd("pend_masked_src5", 8'hF0, 8'h20);
    tick();
    tick();
    irq_is("irq_masked_low", 1'b0);
    rd("cause_masked_none", 8'hF2, 8'hFF);
    wr(8'hF1, 8'h20);
    irq_is("irq_unmask_edge", 1'b0);
    tick();
    irq_is("irq_after_unmask", 1'b1);
    rd("cause_src5", 8'hF2, 8'h05);
    wr(8'hF0, 8'h20);
    tick();
    tick();
    irq_is("irq_after_ack5", 1'b0);

    // Priority: sources 1 and 6; acking 1 keeps the request active
    wr(8'hF1, 8'h42);
    pulse(8'h42);
    tick();
    rd("pend_src1_src6", 8'hF0, 8'h42);
    tick();
    irq_is("irq_src1_src6", 1'b1);
    rd("cause_src1_first", 8'hF2, 8'h01);
    wr(8'hF0, 8'h02);
    rd("pend_after_ack1", 8'hF0, 8'h40);
    rd("cause_src6_next", 8'hF2, 8'h06);
    tick();
    irq_is("irq_still_high_src6", 1'b1);
    wr(8'hF0, 8'h40);
    tick();
    tick();
    irq_is("irq_after_ack6", 1'b0);
    wr(8'hF1, 8'h00);

    // CAUSE is read-only
    wr(8'hF2, 8'h00);
    rd("cause_write_ignored", 8'hF2, 8'hFF);

    // Offset 3
    wr(8'hF3, 8'h0A);
`ifdef INTC_LEVEL_CFG_EN
    rd("level_readback", 8'hF3, 8'h0A);
    wr(8'hF3, 8'h00);
`else
    rd("ofs3_write_ignored", 8'hF3, 8'h00);
`endif

    // Same-cycle W1C and new edge on source 3: set wins
    pulse(8'h08);
    tick();
    rd("pend_src3_first", 8'hF0, 8'h08);
    tick();
    tick();
    tick();
    IRQ_IN[3] = 1'b1;
    tick();
    tick();
    wr(8'hF0, 8'h08);
    rd("pend_collision_set_wins", 8'hF0, 8'h08);
    IRQ_IN[3] = 1'b0;
    wr(8'hF0, 8'h08);
    rd("pend_plain_w1c", 8'hF0, 8'h00);

`ifdef INTC_LEVEL_CFG_EN
    // Level mode: W1C is overridden while the line is high
    tick();
    tick();
    tick();
    wr(8'hF3, 8'h08);
    IRQ_IN[3] = 1'b1;
    tick();
    tick();
    tick();
    rd("pend_level_set", 8'hF0, 8'h08);
    wr(8'hF0, 8'h08);
    rd("pend_level_w1c_blocked", 8'hF0, 8'h08);
    IRQ_IN[3] = 1'b0;
    tick();
    tick();
    tick();
    wr(8'hF0, 8'h08);
    rd("pend_level_w1c_after_fall", 8'hF0, 8'h00);
    wr(8'hF3, 8'h00);
`endif

    // Async reset while a request is outstanding
    wr(8'hF1, 8'h01);
    pulse(8'h01);
    tick();
    tick();
    irq_is("irq_before_reset", 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    irq_is("irq_async_reset", 1'b0);
    rd("pend_in_reset", 8'hF0, 8'h00);
    rd("mask_in_reset", 8'hF1, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tick();
    irq_is("irq_after_rerelease", 1'b0);
    rd("pend_after_rerelease", 8'hF0, 8'h00);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
